fpu_dispatch: RTL and testbench

Instruction dispatcher directly upstream of the floating-point coprocessor. It accepts 32-bit FP instruction words from the integer core over a valid/ready handshake and buffers them in a small FIFO. It decodes register fields, drives the coprocessor's opcode, register-address and write ports one instruction at a time, and sequences float loads (memory data into the register file) and stores (register file out to the core). All issue is gated by `cache_done`, because the coprocessor ignores every cycle in which `cache_done` is high.

---
 rtl/fpu_pkg.sv | 39 +++
 rtl/fpu_instr_fifo.sv | 36 +++
 rtl/fpu_dispatch.sv | 105 ++++++++++
 tb/tb_fpu_dispatch.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// fpu_pkg: opcodes, dispatcher states and instruction field slices
package fpu_pkg;
    localparam logic [5:0] OP_NOP   = 6'b000000;
    localparam logic [5:0] OP_ADD   = 6'b110000;
    localparam logic [5:0] OP_SUB   = 6'b110001;
    localparam logic [5:0] OP_MUL   = 6'b110010;
    localparam logic [5:0] OP_DIV   = 6'b110011;
    localparam logic [5:0] OP_CMP   = 6'b110100;
    localparam logic [5:0] OP_REV   = 6'b110101;
    localparam logic [5:0] OP_ROUND = 6'b110110;
    localparam logic [5:0] OP_LOAD  = 6'b001010;
    localparam logic [5:0] OP_STORE = 6'b001011;

    typedef enum logic [2:0] {IDLE, LD_WAIT, LD_WR, ST_CAP, ST_HOLD} state_t;

    function automatic logic [5:0] f_op(input logic [31:0] i);
        return i[31:26];
    endfunction

    function automatic logic [4:0] f_rs(input logic [31:0] i);
        return i[25:21];
    endfunction

    function automatic logic [4:0] f_rt(input logic [31:0] i);
        return i[20:16];
    endfunction

    function automatic logic [4:0] f_rd(input logic [31:0] i);
        return i[15:11];
    endfunction

    function automatic logic [15:0] f_imm(input logic [31:0] i);
        return i[15:0];
    endfunction

    function automatic logic is_alu(input logic [5:0] op);
        return op >= OP_ADD && op <= OP_ROUND;
    endfunction
endpackage

// File: rtl/fpu_instr_fifo.sv
// fpu_instr_fifo: DEPTH x W synchronous FIFO, wrap-bit pointers, head read combinationally
module fpu_instr_fifo #(
    parameter int DEPTH = 4,
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0]  wptr, rptr;
    logic [W-1:0] mem [DEPTH];
    logic         do_push, do_pop;
    assign empty   = wptr == rptr;
    assign full    = (wptr ^ rptr) == {1'b1, {AW{1'b0}}};
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr[AW-1:0]];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop) rptr <= rptr + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/fpu_dispatch.sv
// fpu_dispatch: buffers FP instructions and issues them to the coprocessor in order,
// sequencing float loads into the register file and stores back to the core
module fpu_dispatch
    import fpu_pkg::*;
#(
    parameter int         DEPTH    = 4,
    parameter logic [5:0] LOAD_OP  = OP_LOAD,
    parameter logic [5:0] STORE_OP = OP_STORE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    output logic        ld_req,
    output logic [15:0] ld_imm,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        st_valid,
    input  logic        st_ready,
    output logic [31:0] st_data,
    input  logic        cache_done,
    input  logic [31:0] cop_outdata,
    output logic [5:0]  opcode,
    output logic [4:0]  addr_reg_in1,
    output logic [4:0]  addr_reg_in2,
    output logic [4:0]  addr_destination,
    output logic [4:0]  write_address,
    output logic        write_data_enable,
    output logic [31:0] inputdata_float,
    output logic        illegal,
    output logic        busy
);
    state_t      state;
    logic [31:0] head, ld_data;
    logic [4:0]  ld_rt;
    logic [5:0]  op;
    logic        empty, full, pop, ready_head;
    logic        iss_alu, iss_st, iss_ld, drop;

    fpu_instr_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (in_valid),
        .pop   (pop),
        .wdata (in_instr),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    assign in_ready   = !full;
    assign op         = f_op(head);
    assign ready_head = state == IDLE && !empty;
    // Loads bypass the cache_done gate: they only request memory, the write is gated later
    assign iss_alu = ready_head && is_alu(op) && !cache_done;
    assign iss_st  = ready_head && op == STORE_OP && !cache_done;
    assign iss_ld  = ready_head && op == LOAD_OP;
    assign drop    = ready_head && !is_alu(op) && op != STORE_OP && op != LOAD_OP;
    assign pop     = iss_alu || iss_st || iss_ld || drop;

    assign opcode            = iss_alu ? op : iss_st ? STORE_OP : OP_NOP;
    assign addr_reg_in1      = iss_alu ? f_rs(head) : '0;
    assign addr_reg_in2      = (iss_alu || iss_st) ? f_rt(head) : '0;
    assign addr_destination  = iss_alu ? f_rd(head) : '0;
    assign write_data_enable = state == LD_WR;
    assign write_address     = write_data_enable ? ld_rt : '0;
    assign inputdata_float   = write_data_enable ? ld_data : '0;
    assign ld_req            = iss_ld;
    assign ld_imm            = iss_ld ? f_imm(head) : '0;
    assign illegal           = drop;
    assign st_valid          = state == ST_HOLD;
    assign busy              = !empty || state != IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ld_rt   <= '0;
            ld_data <= '0;
            st_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (iss_ld) begin
                        ld_rt <= f_rt(head);
                        state <= LD_WAIT;
                    end else if (iss_st) state <= ST_CAP;
                end
                LD_WAIT: begin
                    if (mem_rvalid) begin
                        ld_data <= mem_rdata;
                        state   <= LD_WR;
                    end
                end
                LD_WR:   if (!cache_done) state <= IDLE;
                ST_CAP: begin
                    st_data <= cop_outdata;
                    state   <= ST_HOLD;
                end
                ST_HOLD: if (st_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fpu_dispatch.sv
// tb_fpu_dispatch: directed scenarios with hand-computed expectations for fpu_dispatch
module tb_fpu_dispatch;
    localparam logic [5:0] ADD = 6'b110000, SUB = 6'b110001, MUL = 6'b110010, DIV = 6'b110011;
    localparam logic [5:0] CMP = 6'b110100, LD = 6'b001010, ST = 6'b001011, BAD = 6'b111111;

    logic        clk = 0, rst_n = 0;
    logic        in_valid = 0, mem_rvalid = 0, st_ready = 0, cache_done = 0;
    logic [31:0] in_instr = '0, mem_rdata = '0, cop_outdata = '0;
    logic        in_ready, ld_req, st_valid, write_data_enable, illegal, busy;
    logic [15:0] ld_imm;
    logic [31:0] st_data, inputdata_float;
    logic [5:0]  opcode;
    logic [4:0]  addr_reg_in1, addr_reg_in2, addr_destination, write_address;
    int          checks = 0, errors = 0;

    fpu_dispatch dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .ld_req(ld_req), .ld_imm(ld_imm), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .st_valid(st_valid), .st_ready(st_ready), .st_data(st_data), .cache_done(cache_done),
        .cop_outdata(cop_outdata), .opcode(opcode), .addr_reg_in1(addr_reg_in1),
        .addr_reg_in2(addr_reg_in2), .addr_destination(addr_destination),
        .write_address(write_address), .write_data_enable(write_data_enable),
        .inputdata_float(inputdata_float), .illegal(illegal), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc(logic [5:0] o, logic [4:0] a, logic [4:0] b, logic [4:0] c);
        return {o, a, b, c, 11'd0};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0; in_valid = 1; in_instr = enc(ADD, 1, 2, 3);
        repeat (3) cyc();
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
        checks++; if (opcode !== 6'd0) begin errors++; $display("FAIL rst_opcode got %b exp 000000", opcode); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
        checks++; if ({st_valid, write_data_enable, ld_req, illegal} !== 4'b0) begin errors++; $display("FAIL rst_flags got %b exp 0000", {st_valid, write_data_enable, ld_req, illegal}); end
        checks++; if (st_data !== 32'd0) begin errors++; $display("FAIL rst_st_data got %h exp 0", st_data); end
        cyc();
        in_valid = 0; rst_n = 1;
        cyc();
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_nopush busy got %b exp 0", busy); end
    endtask

    task automatic test_alu();
        cyc(); in_valid = 1; in_instr = enc(ADD, 3, 4, 5); #1;
        cyc(); in_valid = 0; #1;
        checks++; if ({opcode, addr_reg_in1, addr_reg_in2, addr_destination} !== {ADD, 5'd3, 5'd4, 5'd5}) begin errors++; $display("FAIL alu_issue got %b/%0d/%0d/%0d exp 110000/3/4/5", opcode, addr_reg_in1, addr_reg_in2, addr_destination); end
        cyc(); #1;
        checks++; if ({opcode, addr_reg_in1, busy} !== 12'd0) begin errors++; $display("FAIL alu_once opcode %b in1 %0d busy %b exp 0", opcode, addr_reg_in1, busy); end
    endtask

    task automatic test_back_to_back();
        cyc(); cache_done = 1; in_valid = 1; in_instr = enc(MUL, 1, 2, 3); #1;
        cyc(); in_instr = enc(DIV, 6, 7, 8); #1;
        checks++; if (opcode !== 6'd0) begin errors++; $display("FAIL stall_hold1 opcode got %b exp 0", opcode); end
        cyc(); in_valid = 0; #1;
        checks++; if (opcode !== 6'd0 || busy !== 1'b1) begin errors++; $display("FAIL stall_hold2 opcode %b busy %b exp 0/1", opcode, busy); end
        cyc(); cache_done = 0; #1;
        checks++; if ({opcode, addr_reg_in1, addr_reg_in2, addr_destination} !== {MUL, 5'd1, 5'd2, 5'd3}) begin errors++; $display("FAIL b2b_mul got %b/%0d/%0d/%0d exp 110010/1/2/3", opcode, addr_reg_in1, addr_reg_in2, addr_destination); end
        cyc(); #1;
        checks++; if ({opcode, addr_reg_in1, addr_reg_in2, addr_destination} !== {DIV, 5'd6, 5'd7, 5'd8}) begin errors++; $display("FAIL b2b_div got %b/%0d/%0d/%0d exp 110011/6/7/8", opcode, addr_reg_in1, addr_reg_in2, addr_destination); end
        cyc(); #1;
        checks++; if (opcode !== 6'd0) begin errors++; $display("FAIL b2b_after opcode got %b exp 0", opcode); end
        cache_done = 1;
        for (int i = 0; i < 4; i++) begin
            cyc(); in_valid = 1; in_instr = enc(SUB, 5'(i), 5'(i + 1), 5'(i + 2)); #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_ready%0d got %b exp 1", i, in_ready); end
        end
        cyc(); in_instr = enc(CMP, 9, 9, 9); #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", in_ready); end
        for (int i = 0; i < 4; i++) begin
            cyc(); in_valid = 0; cache_done = 0; #1;
            checks++; if (opcode !== SUB || addr_reg_in1 !== 5'(i) || addr_destination !== 5'(i + 2)) begin errors++; $display("FAIL drain%0d got %b/%0d/%0d exp 110001/%0d/%0d", i, opcode, addr_reg_in1, addr_destination, i, i + 2); end
        end
        cyc(); #1;
        checks++; if (opcode !== 6'd0 || busy !== 1'b0) begin errors++; $display("FAIL full_nopush opcode %b busy %b exp 0/0", opcode, busy); end
    endtask

    task automatic test_load();
        cyc(); mem_rvalid = 1; mem_rdata = 32'hDEADBEEF; in_valid = 1; in_instr = {LD, 5'd0, 5'd7, 16'h1234}; #1;
        cyc(); mem_rvalid = 0; in_valid = 0; cache_done = 1; #1;
        checks++; if (ld_req !== 1'b1 || ld_imm !== 16'h1234 || opcode !== 6'd0) begin errors++; $display("FAIL ld_req got %b imm %h op %b exp 1/1234/0", ld_req, ld_imm, opcode); end
        cyc(); cache_done = 0; #1;
        checks++; if (ld_req !== 1'b0 || write_data_enable !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL ld_wait req %b wde %b busy %b exp 0/0/1", ld_req, write_data_enable, busy); end
        cyc(); mem_rvalid = 1; mem_rdata = 32'h3F800000; #1;
        checks++; if (write_data_enable !== 1'b0) begin errors++; $display("FAIL ld_early wde got %b exp 0", write_data_enable); end
        cyc(); mem_rvalid = 0; mem_rdata = '0; cache_done = 1; #1;
        checks++; if ({write_data_enable, write_address, inputdata_float, opcode} !== {1'b1, 5'd7, 32'h3F800000, 6'd0}) begin errors++; $display("FAIL ld_write wde %b wa %0d data %h op %b exp 1/7/3f800000/0", write_data_enable, write_address, inputdata_float, opcode); end
        cyc(); cache_done = 0; #1;
        checks++; if (write_data_enable !== 1'b1 || inputdata_float !== 32'h3F800000) begin errors++; $display("FAIL ld_extend wde %b data %h exp 1/3f800000", write_data_enable, inputdata_float); end
        cyc(); #1;
        checks++; if (write_data_enable !== 1'b0 || inputdata_float !== 32'd0 || busy !== 1'b0) begin errors++; $display("FAIL ld_done wde %b data %h busy %b exp 0/0/0", write_data_enable, inputdata_float, busy); end
    endtask

    task automatic test_store();
        cyc(); in_valid = 1; in_instr = {ST, 5'd0, 5'd2, 16'd0}; #1;
        cyc(); in_valid = 0; #1;
        checks++; if ({opcode, addr_reg_in1, addr_reg_in2, addr_destination} !== {ST, 5'd0, 5'd2, 5'd0}) begin errors++; $display("FAIL st_issue got %b/%0d/%0d/%0d exp 001011/0/2/0", opcode, addr_reg_in1, addr_reg_in2, addr_destination); end
        cyc(); cop_outdata = 32'h40490FDB; #1;
        checks++; if (st_valid !== 1'b0) begin errors++; $display("FAIL st_cap st_valid got %b exp 0", st_valid); end
        for (int i = 0; i < 3; i++) begin
            cyc(); cop_outdata = 32'h11111111; st_ready = (i == 2); #1;
            checks++; if (st_valid !== 1'b1 || st_data !== 32'h40490FDB) begin errors++; $display("FAIL st_hold%0d valid %b data %h exp 1/40490fdb", i, st_valid, st_data); end
        end
        cyc(); st_ready = 0; #1;
        checks++; if (st_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL st_done valid %b busy %b exp 0/0", st_valid, busy); end
    endtask

    task automatic test_illegal();
        cyc(); in_valid = 1; in_instr = enc(BAD, 1, 1, 1); #1;
        cyc(); in_instr = enc(ADD, 9, 10, 11); #1;
        checks++; if (illegal !== 1'b1 || opcode !== 6'd0 || addr_reg_in1 !== 5'd0) begin errors++; $display("FAIL ill_pulse got %b op %b in1 %0d exp 1/0/0", illegal, opcode, addr_reg_in1); end
        cyc(); in_valid = 0; #1;
        checks++; if (illegal !== 1'b0 || {opcode, addr_reg_in1, addr_reg_in2, addr_destination} !== {ADD, 5'd9, 5'd10, 5'd11}) begin errors++; $display("FAIL ill_next ill %b got %b/%0d/%0d/%0d exp 0 110000/9/10/11", illegal, opcode, addr_reg_in1, addr_reg_in2, addr_destination); end
    endtask

    task automatic test_reset_mid_load();
        cyc(); in_valid = 1; in_instr = {LD, 5'd0, 5'd4, 16'h0042}; #1;
        cyc(); in_valid = 0; #1;
        checks++; if (ld_req !== 1'b1) begin errors++; $display("FAIL rl_req got %b exp 1", ld_req); end
        cyc(); rst_n = 0; #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rl_busy got %b exp 0", busy); end
        cyc(); rst_n = 1; #1;
        cyc(); mem_rvalid = 1; mem_rdata = 32'hCAFEF00D; #1;
        cyc(); mem_rvalid = 0; #1;
        checks++; if (write_data_enable !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rl_nowrite wde %b busy %b exp 0/0", write_data_enable, busy); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_back_to_back();
        test_load();
        test_store();
        test_illegal();
        test_reset_mid_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
